// File: rtl/sprite_line_engine.sv
// sprite_line_engine: scanline sprite engine that scans attributes, renders into a ping-pong line buffer and streams the other bank.
// Define SPRITE_PRIORITY_EN for first-come (lowest index wins) pixel priority.
module sprite_line_engine #(
  parameter int NUM_OBJ      = 128,
  parameter int MAX_PER_LINE = 16,
  parameter int SPR_W        = 16,
  parameter int SPR_H        = 16,
  parameter int BPP          = 2,
  parameter int PAL_W        = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         line_start,
  input  logic                         hblank_start,
  input  logic [7:0]                   vline,
  input  logic                         flip,
  input  logic [7:0]                   hpos,
  input  logic                         pix_en,
  output logic [$clog2(NUM_OBJ)-1:0]   attr_addr,
  output logic                         attr_rd,
  input  logic [31:0]                  attr_data,
  output logic [7+$clog2(SPR_H)-1:0]   rom_addr,
  output logic                         rom_req,
  input  logic                         rom_ack,
  input  logic [SPR_W*BPP-1:0]         rom_data,
  output logic [BPP-1:0]               obj_vid,
  output logic [PAL_W-1:0]             obj_col,
  output logic                         busy,
  output logic                         overflow,
  output logic                         late
);
  localparam int AW = $clog2(NUM_OBJ);
  localparam int RW = $clog2(SPR_H);
  localparam int PW = $clog2(SPR_W);
  localparam int EI = $clog2(MAX_PER_LINE);
  localparam int CW = $clog2(MAX_PER_LINE + 1);
  localparam int EW = RW + 7 + 1 + PAL_W + 8;
  typedef enum logic [2:0] {IDLE, SCAN, WAIT_HB, FETCH, DRAW, DONE} state_t;
  state_t state, nxt;
  logic [AW:0] idx;
  logic rd_q, flip_q, bank;
  logic [7:0] vline_q;
  logic [CW-1:0] cnt;
  logic [EI-1:0] entry;
  logic [PW-1:0] px, sl;
  logic [SPR_W*BPP-1:0] row_q;
  logic [EW-1:0] scratch [MAX_PER_LINE];
  logic [1:0][255:0] valid;
  logic [PAL_W+BPP-1:0] mem [2][256];
  logic [RW-1:0] e_row;
  logic [6:0] e_tile;
  logic e_hf;
  logic [PAL_W-1:0] e_pal;
  logic [7:0] e_x, dy, ra;
  logic [8:0] tgt;
  logic [BPP-1:0] pix;
  logic hit, store, last_px, last_ent, we, unused_bits;
  assign unused_bits = ^attr_data[22:16+PAL_W];
  assign {e_row, e_tile, e_hf, e_pal, e_x} = scratch[entry];
  assign dy       = vline_q - attr_data[7:0];
  assign hit      = rd_q && dy < 8'(SPR_H);
  assign store    = state == SCAN && !line_start && !hblank_start && hit && cnt < CW'(MAX_PER_LINE);
  assign last_px  = px == PW'(SPR_W - 1);
  assign last_ent = CW'(entry) + CW'(1) == cnt;
  assign sl       = e_hf ? ~px : px;
  assign pix      = row_q[BPP*int'(sl) +: BPP];
  assign tgt      = {1'b0, e_x} + 9'(px);
  // Clipped and transparent pixels never touch the buffer.
`ifdef SPRITE_PRIORITY_EN
  assign we = state == DRAW && !line_start && pix != '0 && !tgt[8] && !valid[bank][tgt[7:0]];
`else
  assign we = state == DRAW && !line_start && pix != '0 && !tgt[8];
`endif
  assign ra        = flip_q ? ~hpos : hpos;
  assign attr_rd   = state == SCAN && !idx[AW];
  assign attr_addr = idx[AW-1:0];
  assign rom_req   = rst_n && !line_start && state == FETCH;
  assign rom_addr  = state == FETCH ? {e_tile, e_row} : '0;
  assign busy      = state inside {SCAN, WAIT_HB, FETCH, DRAW};
  always_comb begin
    nxt = state;
    case (state)
      SCAN:    nxt = hblank_start ? (cnt == '0 ? DONE : FETCH) : (idx == (AW+1)'(NUM_OBJ) ? WAIT_HB : SCAN);
      WAIT_HB: nxt = hblank_start ? (cnt == '0 ? DONE : FETCH) : WAIT_HB;
      FETCH:   nxt = rom_ack ? DRAW : FETCH;
      DRAW:    nxt = last_px ? (last_ent ? DONE : FETCH) : DRAW;
      default: nxt = state;
    endcase
    if (line_start) nxt = SCAN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      rd_q     <= 1'b0;
      vline_q  <= '0;
      flip_q   <= 1'b0;
      cnt      <= '0;
      entry    <= '0;
      px       <= '0;
      bank     <= 1'b0;
      overflow <= 1'b0;
      late     <= 1'b0;
    end else begin
      state <= nxt;
      rd_q  <= attr_rd && !line_start;
      if (line_start) begin
        bank     <= ~bank;
        vline_q  <= vline;
        flip_q   <= flip;
        cnt      <= '0;
        overflow <= 1'b0;
        idx      <= '0;
        entry    <= '0;
        late     <= state == FETCH || state == DRAW;
      end else begin
        if (state == SCAN) idx <= idx + 1'b1;
        if (store) cnt <= cnt + 1'b1;
        if (state == SCAN && !hblank_start && hit && cnt == CW'(MAX_PER_LINE)) overflow <= 1'b1;
        if (state == FETCH && rom_ack) px <= '0;
        if (state == DRAW) begin
          px <= px + 1'b1;
          if (last_px) entry <= entry + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (store) scratch[cnt[EI-1:0]] <= {dy[RW-1:0] ^ {RW{attr_data[15]}}, attr_data[14:8], attr_data[23], attr_data[16 +: PAL_W], attr_data[31:24]};
    if (state == FETCH && rom_ack) row_q <= rom_data;
    if (we) mem[bank][tgt[7:0]] <= {e_pal, pix};
  end
  // Reading an output entry clears it so the bank is empty when it becomes the render bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid   <= '0;
      obj_vid <= '0;
      obj_col <= '0;
    end else begin
      if (we) valid[bank][tgt[7:0]] <= 1'b1;
      if (pix_en) begin
        valid[~bank][ra]   <= 1'b0;
        {obj_col, obj_vid} <= valid[~bank][ra] ? mem[~bank][ra] : '0;
      end
    end
  end
endmodule
